spi_ram_arbiter: RTL and testbench
==================================

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH_BYTES, default 2, bytes per RAM word.
REQ-002 SHALL have parameter ADDR_BITS, default 16, RAM address width.
REQ-003 SHALL have parameter FIXED_PRIORITY, default 0; 0 = round-robin, 1 = port 0 always wins.
REQ-004 clk  input  1  single clock; all state on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 pN_req  input  1  (N=0,1) transaction request, level, held until pN_ack.
REQ-007 pN_we  input  1  1 = write, 0 = read.
REQ-008 pN_addr  input  ADDR_BITS  word address.
REQ-009 pN_wdata  input  DATA_WIDTH_BYTES*8  write data.
REQ-010 pN_ack  output  1  one-cycle completion pulse.
REQ-011 pN_rdata  output  DATA_WIDTH_BYTES*8  read data, valid with pN_ack, held until next read completion on that port.
REQ-012 ram_start_read, ram_start_write  output  1  one-cycle start pulses to the SPI RAM controller.
REQ-013 ram_addr  output  ADDR_BITS; ram_wdata  output  DATA_WIDTH_BYTES*8; both to controller.
REQ-014 ram_busy  input  1; ram_rdata  input  DATA_WIDTH_BYTES*8; both from controller.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK; all outputs registered.
REQ-016 IDLE: if any pN_req high, grant one port, latch its we/addr/wdata into ram_addr/ram_wdata, go to ISSUE; else stay.
REQ-017 Round-robin: both requesting -> grant port not granted last; last-grant pointer updates on each grant only.
REQ-018 FIXED_PRIORITY=1: both requesting -> port 0 granted.
REQ-019 ISSUE (exactly 1 cycle): assert ram_start_write if latched we, else ram_start_read; go to WAIT; ram_busy ignored in this cycle.
REQ-020 WAIT: stay while ram_busy=1; when ram_busy=0, capture ram_rdata into granted pN_rdata (reads only) and go to ACK.
REQ-021 ACK (exactly 1 cycle): pulse granted pN_ack; other port's ack stays 0; go to IDLE.
REQ-022 Never both start pulses together, never both acks together, at most one transaction outstanding.
REQ-023 ram_addr/ram_wdata SHALL hold latched values from grant until next grant; input changes after grant ignored.
REQ-024 pN_req dropped after grant: transaction still completes and pN_ack still pulses.
REQ-025 Requester SHALL deassert or re-present req the cycle after pN_ack; req still high in IDLE counts as a new request.
REQ-026 Latency: req in cycle 0 from IDLE -> start in cycle 1 -> ack in cycle B+3, B = controller busy cycles (8+ADDR_BITS+8*DATA_WIDTH_BYTES; 40 at defaults).
REQ-027 Minimum spacing between consecutive start pulses: B+4 cycles (one IDLE cycle after ACK).
REQ-028 Write completion SHALL leave pN_rdata unchanged.

Reset
REQ-029 rst high SHALL immediately force state IDLE; start pulses, acks, ram_addr, ram_wdata, pN_rdata = 0; last-grant pointer = port 1 (port 0 wins first tie).
REQ-030 rst mid-transaction SHALL abort without ack; controller is reset by the same reset at integration.
REQ-031 First grant possible in first clk edge after rst deasserts.

Verification
REQ-032 p0 read addr 0x1234, model returns 0xBEEF -> ram_start_read cycle 1, ram_addr=0x1234, p0_ack cycle 43, p0_rdata=0xBEEF.
REQ-033 p1 write addr 0x0010 data 0xA5A5 -> ram_start_write once, ram_wdata=0xA5A5, p1_ack cycle 43, p1_rdata unchanged.
REQ-034 Both req continuously, round-robin -> grant order 0,1,0,1; starts 44 cycles apart; no ack overlap.
REQ-035 FIXED_PRIORITY=1, both req continuously -> every grant to port 0; p1 starved.
REQ-036 rst asserted cycle 20 of p0 read -> all outputs 0 same cycle, no p0_ack; after release p0 req re-granted from IDLE.
REQ-037 p0_addr changed and p0_req dropped during WAIT -> ram_addr keeps original, p0_ack still pulses once.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of a single SPI RAM controller.
// One transaction at a time: grant a port, issue one start pulse,
// wait for the controller to finish, then pulse that port's ack.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch the winner's request
// ST_ISSUE | start pulse to the controller is high (one cycle)
// ST_WAIT  | controller busy; leave when ram_busy drops
// ST_ACK   | ack pulse to the granted port is high (one cycle)
module spi_ram_arbiter #(
    parameter int DATA_WIDTH_BYTES = 2,
    parameter int ADDR_BITS        = 16,
    parameter int FIXED_PRIORITY   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            p0_req,
    input  logic                            p0_we,
    input  logic [ADDR_BITS-1:0]            p0_addr,
    input  logic [DATA_WIDTH_BYTES*8-1:0]   p0_wdata,
    output logic                            p0_ack,
    output logic [DATA_WIDTH_BYTES*8-1:0]   p0_rdata,
    input  logic                            p1_req,
    input  logic                            p1_we,
    input  logic [ADDR_BITS-1:0]            p1_addr,
    input  logic [DATA_WIDTH_BYTES*8-1:0]   p1_wdata,
    output logic                            p1_ack,
    output logic [DATA_WIDTH_BYTES*8-1:0]   p1_rdata,
    output logic                            ram_start_read,
    output logic                            ram_start_write,
    output logic [ADDR_BITS-1:0]            ram_addr,
    output logic [DATA_WIDTH_BYTES*8-1:0]   ram_wdata,
    input  logic                            ram_busy,
    input  logic [DATA_WIDTH_BYTES*8-1:0]   ram_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    logic [1:0] state;
    logic       gnt_port;   // port owning the current transaction
    logic       last_gnt;   // port granted most recently (round-robin pointer)
    logic       lat_we;     // latched direction of the current transaction
    logic       any_req;
    logic       sel_port;
    logic       sel_we;

    // Pick the winner among current requesters; only used in ST_IDLE.
    always_comb begin
        any_req  = p0_req | p1_req;
        sel_port = 1'b0;
        if (p0_req && p1_req) begin
            sel_port = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_gnt;
        end else begin
            sel_port = p1_req;
        end
        sel_we = sel_port ? p1_we : p0_we;
    end

    // Transaction sequencer; start and ack flops are set on entry to the
    // state they belong to so every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            gnt_port        <= 1'b0;
            last_gnt        <= 1'b1;
            lat_we          <= 1'b0;
            ram_start_read  <= 1'b0;
            ram_start_write <= 1'b0;
            ram_addr        <= '0;
            ram_wdata       <= '0;
            p0_ack          <= 1'b0;
            p1_ack          <= 1'b0;
            p0_rdata        <= '0;
            p1_rdata        <= '0;
        end else begin
            ram_start_read  <= 1'b0;
            ram_start_write <= 1'b0;
            p0_ack          <= 1'b0;
            p1_ack          <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_port        <= sel_port;
                        last_gnt        <= sel_port;
                        lat_we          <= sel_we;
                        ram_addr        <= sel_port ? p1_addr : p0_addr;
                        ram_wdata       <= sel_port ? p1_wdata : p0_wdata;
                        ram_start_write <= sel_we;
                        ram_start_read  <= ~sel_we;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Controller may not have raised busy yet; do not look at it here.
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ram_busy) begin
                        if (!lat_we) begin
                            if (gnt_port) begin
                                p1_rdata <= ram_rdata;
                            end else begin
                                p0_rdata <= ram_rdata;
                            end
                        end
                        p0_ack <= ~gnt_port;
                        p1_ack <= gnt_port;
                        state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority.
// A behavioural SPI RAM controller model sits behind each instance.
module tb_spi_ram_arbiter;

    localparam int B = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req [2];
    logic        p0_we [2];
    logic [15:0] p0_addr [2];
    logic [15:0] p0_wdata [2];
    logic        p0_ack [2];
    logic [15:0] p0_rdata [2];
    logic        p1_req [2];
    logic        p1_we [2];
    logic [15:0] p1_addr [2];
    logic [15:0] p1_wdata [2];
    logic        p1_ack [2];
    logic [15:0] p1_rdata [2];
    logic        sr [2];
    logic        sw [2];
    logic [15:0] ra [2];
    logic [15:0] wd [2];
    logic        busy [2];
    logic [15:0] rdat [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int viol = 0;
    int ack_cnt [2][2] = '{default: 0};
    int start_cnt [2] = '{default: 0};
    int cnt [2];
    logic [15:0] wlog [2];
    logic [15:0] mem [logic [16:0]];

    always #5 clk = ~clk;

    spi_ram_arbiter #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(16), .FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[0]), .p0_we(p0_we[0]), .p0_addr(p0_addr[0]), .p0_wdata(p0_wdata[0]),
        .p0_ack(p0_ack[0]), .p0_rdata(p0_rdata[0]),
        .p1_req(p1_req[0]), .p1_we(p1_we[0]), .p1_addr(p1_addr[0]), .p1_wdata(p1_wdata[0]),
        .p1_ack(p1_ack[0]), .p1_rdata(p1_rdata[0]),
        .ram_start_read(sr[0]), .ram_start_write(sw[0]), .ram_addr(ra[0]), .ram_wdata(wd[0]),
        .ram_busy(busy[0]), .ram_rdata(rdat[0])
    );

    spi_ram_arbiter #(.DATA_WIDTH_BYTES(2), .ADDR_BITS(16), .FIXED_PRIORITY(1)) u_fp (
        .clk(clk), .rst(rst),
        .p0_req(p0_req[1]), .p0_we(p0_we[1]), .p0_addr(p0_addr[1]), .p0_wdata(p0_wdata[1]),
        .p0_ack(p0_ack[1]), .p0_rdata(p0_rdata[1]),
        .p1_req(p1_req[1]), .p1_we(p1_we[1]), .p1_addr(p1_addr[1]), .p1_wdata(p1_wdata[1]),
        .p1_ack(p1_ack[1]), .p1_rdata(p1_rdata[1]),
        .ram_start_read(sr[1]), .ram_start_write(sw[1]), .ram_addr(ra[1]), .ram_wdata(wd[1]),
        .ram_busy(busy[1]), .ram_rdata(rdat[1])
    );

    // Cycle counter; value seen at a negedge is the index of that cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: busy for exactly B cycles starting the cycle after a start pulse.
    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                busy[g] <= 1'b0;
                cnt[g]  <= 0;
                rdat[g] <= '0;
                wlog[g] <= '0;
            end else if (busy[g]) begin
                if (cnt[g] == 1) busy[g] <= 1'b0;
                else cnt[g] <= cnt[g] - 1;
            end else if (sr[g]) begin
                busy[g] <= 1'b1;
                cnt[g]  <= B;
                rdat[g] <= mem[{(g == 1), ra[g]}];
            end else if (sw[g]) begin
                busy[g] <= 1'b1;
                cnt[g]  <= B;
                wlog[g] <= wd[g];
            end
        end
    end

    // Event tallies and exclusivity watch.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if ((sr[g] && sw[g]) || (p0_ack[g] && p1_ack[g])) viol++;
            if (p0_ack[g]) ack_cnt[g][0]++;
            if (p1_ack[g]) ack_cnt[g][1]++;
            if (sr[g] || sw[g]) start_cnt[g]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int d, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sr[d] || sw[d]) begin
                c = cyc;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int d, output int c, output int port);
        c = -1;
        port = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p0_ack[d] || p1_ack[d]) begin
                c = cyc;
                port = p1_ack[d] ? 1 : 0;
                break;
            end
        end
    endtask

    initial begin
        int t0, c, p, snap_ack, snap_start;
        for (int g = 0; g < 2; g++) begin
            p0_req[g] = 1'b0; p0_we[g] = 1'b0; p0_addr[g] = '0; p0_wdata[g] = '0;
            p1_req[g] = 1'b0; p1_we[g] = 1'b0; p1_addr[g] = '0; p1_wdata[g] = '0;
        end
        mem[{1'b0, 16'h1234}] = 16'hBEEF;
        mem[{1'b0, 16'h0010}] = 16'h5A5A;
        mem[{1'b0, 16'h0100}] = 16'h0101;
        mem[{1'b0, 16'h0200}] = 16'h0202;
        mem[{1'b0, 16'h0300}] = 16'h1111;
        mem[{1'b1, 16'h0100}] = 16'h7777;
        mem[{1'b1, 16'h0200}] = 16'h8888;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset_pulses", {sr[0], sw[0], p0_ack[0], p1_ack[0], sr[1], sw[1], p0_ack[1], p1_ack[1]}, 0);
        chk("reset_data_rr", {ra[0], wd[0], p0_rdata[0], p1_rdata[0]}, 0);
        chk("reset_data_fp", {ra[1], wd[1], p0_rdata[1], p1_rdata[1]}, 0);
        rst = 1'b0;

        // p0 read 0x1234
        @(negedge clk);
        t0 = cyc;
        p0_we[0] = 1'b0; p0_addr[0] = 16'h1234; p0_req[0] = 1'b1;
        wait_start(0, c);
        chk("rd_start_cycle", c - t0, 1);
        chk("rd_start_kind", {sr[0], sw[0]}, 2'b10);
        chk("rd_ram_addr", ra[0], 16'h1234);
        wait_ack(0, c, p);
        chk("rd_ack_cycle", c - t0, 43);
        chk("rd_ack_port", p, 0);
        chk("rd_p0_rdata", p0_rdata[0], 16'hBEEF);
        p0_req[0] = 1'b0;
        @(negedge clk);
        chk("rd_ack_width", {p0_ack[0], p1_ack[0]}, 0);

        // p1 read 0x0010 to give p1_rdata a known value
        @(negedge clk);
        t0 = cyc;
        p1_we[0] = 1'b0; p1_addr[0] = 16'h0010; p1_req[0] = 1'b1;
        wait_ack(0, c, p);
        chk("p1rd_ack_cycle", c - t0, 43);
        chk("p1rd_ack_port", p, 1);
        chk("p1rd_p1_rdata", p1_rdata[0], 16'h5A5A);
        p1_req[0] = 1'b0;
        @(negedge clk);

        // p1 write 0x0010 <= 0xA5A5
        @(negedge clk);
        t0 = cyc;
        snap_start = start_cnt[0];
        p1_we[0] = 1'b1; p1_addr[0] = 16'h0010; p1_wdata[0] = 16'hA5A5; p1_req[0] = 1'b1;
        wait_start(0, c);
        chk("wr_start_cycle", c - t0, 1);
        chk("wr_start_kind", {sr[0], sw[0]}, 2'b01);
        chk("wr_ram_addr", ra[0], 16'h0010);
        chk("wr_ram_wdata", wd[0], 16'hA5A5);
        wait_ack(0, c, p);
        chk("wr_ack_cycle", c - t0, 43);
        chk("wr_ack_port", p, 1);
        chk("wr_p1_rdata_kept", p1_rdata[0], 16'h5A5A);
        chk("wr_p0_rdata_kept", p0_rdata[0], 16'hBEEF);
        chk("wr_model_data", wlog[0], 16'hA5A5);
        chk("wr_start_once", start_cnt[0] - snap_start, 1);
        p1_req[0] = 1'b0; p1_we[0] = 1'b0;
        @(negedge clk);

        // Both requesting continuously, round-robin; last grant was p1
        @(negedge clk);
        t0 = cyc;
        p0_we[0] = 1'b0; p0_addr[0] = 16'h0100; p0_req[0] = 1'b1;
        p1_we[0] = 1'b0; p1_addr[0] = 16'h0200; p1_req[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_start(0, c);
            chk($sformatf("rr_start_cycle_%0d", k), c - t0, 1 + 44 * k);
            chk($sformatf("rr_grant_addr_%0d", k), ra[0], (k % 2 == 0) ? 16'h0100 : 16'h0200);
            wait_ack(0, c, p);
            chk($sformatf("rr_ack_port_%0d", k), p, k % 2);
            chk($sformatf("rr_ack_cycle_%0d", k), c - t0, 43 + 44 * k);
        end
        p0_req[0] = 1'b0; p1_req[0] = 1'b0;
        chk("rr_p0_rdata", p0_rdata[0], 16'h0101);
        chk("rr_p1_rdata", p1_rdata[0], 16'h0202);
        @(negedge clk);

        // Fixed priority instance: p0 wins every time
        @(negedge clk);
        t0 = cyc;
        p0_we[1] = 1'b0; p0_addr[1] = 16'h0100; p0_req[1] = 1'b1;
        p1_we[1] = 1'b0; p1_addr[1] = 16'h0200; p1_req[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start(1, c);
            chk($sformatf("fp_start_cycle_%0d", k), c - t0, 1 + 44 * k);
            chk($sformatf("fp_grant_addr_%0d", k), ra[1], 16'h0100);
            wait_ack(1, c, p);
            chk($sformatf("fp_ack_port_%0d", k), p, 0);
        end
        p0_req[1] = 1'b0; p1_req[1] = 1'b0;
        chk("fp_p1_starved", ack_cnt[1][1], 0);
        chk("fp_p0_rdata", p0_rdata[1], 16'h7777);
        @(negedge clk);

        // Reset in the middle of a p0 read
        @(negedge clk);
        t0 = cyc;
        snap_ack = ack_cnt[0][0];
        p0_we[0] = 1'b0; p0_addr[0] = 16'h1234; p0_req[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_pre_addr", ra[0], 16'h1234);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_pulses", {sr[0], sw[0], p0_ack[0], p1_ack[0]}, 0);
        chk("rstmid_data", {ra[0], wd[0], p0_rdata[0], p1_rdata[0]}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        wait_start(0, c);
        chk("rstmid_regrant_cycle", c - t0, 1);
        chk("rstmid_no_ack", ack_cnt[0][0] - snap_ack, 0);
        wait_ack(0, c, p);
        chk("rstmid_ack_cycle", c - t0, 43);
        chk("rstmid_p0_rdata", p0_rdata[0], 16'hBEEF);
        p0_req[0] = 1'b0;
        @(negedge clk);

        // Address change and req drop while waiting on the controller
        @(negedge clk);
        t0 = cyc;
        snap_ack = ack_cnt[0][0];
        snap_start = start_cnt[0];
        p0_we[0] = 1'b0; p0_addr[0] = 16'h0300; p0_req[0] = 1'b1;
        wait_start(0, c);
        repeat (9) @(negedge clk);
        p0_addr[0] = 16'hFFFF; p0_req[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("drop_ram_addr_held", ra[0], 16'h0300);
        wait_ack(0, c, p);
        chk("drop_ack_cycle", c - t0, 43);
        chk("drop_ack_port", p, 0);
        chk("drop_p0_rdata", p0_rdata[0], 16'h1111);
        repeat (50) @(negedge clk);
        chk("drop_ack_once", ack_cnt[0][0] - snap_ack, 1);
        chk("drop_start_once", start_cnt[0] - snap_start, 1);

        chk("no_overlap", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
